// File: rtl/lp_ctrl_pkg.sv
// Shared definitions for the low-power issue path.
// Holds the opcode map (shared with the control unit), the sequencer
// state type and small opcode classification helpers.
package lp_ctrl_pkg;

  localparam logic [3:0] OP_NOP    = 4'b0000;
  localparam logic [3:0] OP_ADD    = 4'b0001;
  localparam logic [3:0] OP_SUB    = 4'b0010;
  localparam logic [3:0] OP_AND    = 4'b0011;
  localparam logic [3:0] OP_OR     = 4'b0100;
  localparam logic [3:0] OP_XOR    = 4'b0101;
  localparam logic [3:0] OP_LOAD   = 4'b0110;
  localparam logic [3:0] OP_STORE  = 4'b0111;
  localparam logic [3:0] OP_BRANCH = 4'b1000;
  localparam logic [3:0] OP_JUMP   = 4'b1001;

  typedef enum logic [1:0] {
    RUN,
    MEM_WAIT,
    BR_WAIT,
    PENALTY
  } seq_state_t;

  // Multi-cycle memory operations that hold issue until mem_done.
  function automatic logic is_mem_op(input logic [3:0] op);
    return (op == OP_LOAD) || (op == OP_STORE);
  endfunction

  // Control-flow operations that may redirect fetch.
  function automatic logic is_ctrl_op(input logic [3:0] op);
    return (op == OP_BRANCH) || (op == OP_JUMP);
  endfunction

endpackage

// File: rtl/lp_issue_fifo.sv
// Circular opcode buffer for the issue sequencer.
// Ports:
//   clk, rst     clock, asynchronous active-high reset
//   push, din    write din when not full
//   pop          drop the head entry when not empty
//   clear        empty the buffer; overrides push and pop in the same cycle
//   dout         head entry (valid when !empty)
//   full, empty  occupancy flags
module lp_issue_fifo #(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  logic       pop,
  input  logic       clear,
  input  logic [3:0] din,
  output logic [3:0] dout,
  output logic       full,
  output logic       empty
);

  localparam int AW = $clog2(DEPTH);

  logic [3:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !clear) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/low_power_issue_sequencer.sv
// Issue sequencer between instruction fetch and the low-power control unit.
// Buffers fetched opcodes and issues at most one per cycle; stalls on memory
// ops and unresolved branches, flushes on taken branch or jump, drops NOPs
// silently and holds cu_opcode between issues.
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   in_valid/in_opcode/in_ready  fetch handshake
//   cu_valid/cu_opcode       registered issue to the control unit
//   mem_done                 memory op completion pulse
//   br_resolved/br_taken     branch outcome pulse
//   flush                    one-cycle redirect pulse to fetch
//   busy                     not in RUN or buffer non-empty
//   mem_err                  sticky memory timeout flag
//   stall_cnt                saturating stall cycle count
module low_power_issue_sequencer
  import lp_ctrl_pkg::*;
#(
  parameter int DEPTH        = 4,
  parameter int BR_PENALTY   = 2,
  parameter int JUMP_PENALTY = 1,
  parameter int MEM_TIMEOUT  = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [3:0]  in_opcode,
  output logic        in_ready,
  output logic        cu_valid,
  output logic [3:0]  cu_opcode,
  input  logic        mem_done,
  input  logic        br_resolved,
  input  logic        br_taken,
  output logic        flush,
  output logic        busy,
  output logic        mem_err,
  output logic [15:0] stall_cnt
);

  localparam int PMAX = (BR_PENALTY > JUMP_PENALTY) ? BR_PENALTY : JUMP_PENALTY;
  localparam int PW   = (PMAX < 2) ? 1 : $clog2(PMAX + 1);
  localparam int TW   = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT);

  seq_state_t    state_q, state_d;
  logic [PW-1:0] pen_q, pen_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic          flush_d;
  logic          err_d;
  logic          issue_d;

  logic          fifo_push;
  logic          fifo_pop;
  logic          fifo_clear;
  logic [3:0]    fifo_dout;
  logic          fifo_full;
  logic          fifo_empty;

  assign in_ready  = !fifo_full && (state_q == RUN || state_q == MEM_WAIT);
  assign fifo_push = in_valid && in_ready;
  assign fifo_pop  = (state_q == RUN) && !fifo_empty;
  assign busy      = (state_q != RUN) || !fifo_empty;
  assign issue_d   = fifo_pop && (fifo_dout != OP_NOP);

  lp_issue_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .clear (fifo_clear),
    .din   (in_opcode),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_comb begin
    state_d    = state_q;
    pen_d      = pen_q;
    tmo_d      = tmo_q;
    flush_d    = 1'b0;
    err_d      = mem_err;
    fifo_clear = 1'b0;
    case (state_q)
      RUN: begin
        if (fifo_pop) begin
          if (is_mem_op(fifo_dout)) begin
            state_d = MEM_WAIT;
            tmo_d   = '0;
          end else if (is_ctrl_op(fifo_dout)) begin
            if (fifo_dout == OP_BRANCH) begin
              state_d = BR_WAIT;
            end else begin
              // Clear also swallows any opcode accepted in this same cycle.
              flush_d    = 1'b1;
              fifo_clear = 1'b1;
              pen_d      = PW'(JUMP_PENALTY);
              state_d    = (JUMP_PENALTY == 0) ? RUN : PENALTY;
            end
          end
        end
      end
      MEM_WAIT: begin
        // mem_done takes priority over the timeout on the same cycle.
        if (mem_done) begin
          state_d = RUN;
        end else if (tmo_q == TW'(MEM_TIMEOUT - 1)) begin
          err_d   = 1'b1;
          state_d = RUN;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      BR_WAIT: begin
        if (br_resolved) begin
          if (br_taken) begin
            flush_d    = 1'b1;
            fifo_clear = 1'b1;
            pen_d      = PW'(BR_PENALTY);
            state_d    = (BR_PENALTY == 0) ? RUN : PENALTY;
          end else begin
            state_d = RUN;
          end
        end
      end
      PENALTY: begin
        if (pen_q <= PW'(1)) begin
          pen_d   = '0;
          state_d = RUN;
        end else begin
          pen_d = pen_q - 1'b1;
        end
      end
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= RUN;
      pen_q     <= '0;
      tmo_q     <= '0;
      cu_valid  <= 1'b0;
      cu_opcode <= '0;
      flush     <= 1'b0;
      mem_err   <= 1'b0;
      stall_cnt <= '0;
    end else begin
      state_q  <= state_d;
      pen_q    <= pen_d;
      tmo_q    <= tmo_d;
      cu_valid <= issue_d;
      if (issue_d) cu_opcode <= fifo_dout;
      flush    <= flush_d;
      mem_err  <= err_d;
      if (state_q != RUN && stall_cnt != '1) stall_cnt <= stall_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_low_power_issue_sequencer.sv
// Self-checking bench for low_power_issue_sequencer: a queue-based model of
// the sequencer is compared against the DUT every cycle, with directed
// scenarios pinned by literal expectations followed by randomized traffic.
module tb_low_power_issue_sequencer;

  localparam int DEPTH = 4;
  localparam int BRP   = 2;
  localparam int JPP   = 1;
  localparam int TMO   = 8;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic [3:0]  in_opcode;
  logic        in_ready;
  logic        cu_valid;
  logic [3:0]  cu_opcode;
  logic        mem_done;
  logic        br_resolved;
  logic        br_taken;
  logic        flush;
  logic        busy;
  logic        mem_err;
  logic [15:0] stall_cnt;

  low_power_issue_sequencer #(
    .DEPTH        (DEPTH),
    .BR_PENALTY   (BRP),
    .JUMP_PENALTY (JPP),
    .MEM_TIMEOUT  (TMO)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_opcode   (in_opcode),
    .in_ready    (in_ready),
    .cu_valid    (cu_valid),
    .cu_opcode   (cu_opcode),
    .mem_done    (mem_done),
    .br_resolved (br_resolved),
    .br_taken    (br_taken),
    .flush       (flush),
    .busy        (busy),
    .mem_err     (mem_err),
    .stall_cnt   (stall_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int vectors     = 0;
  int miscompares = 0;
  bit started     = 1'b0;

  // ---------------- behavioural model ----------------
  logic [3:0] mq[$];     // buffered opcodes, head at index 0
  bit         m_mem;     // waiting on memory
  int         m_age;     // cycles already spent waiting on memory
  bit         m_br;      // waiting on branch outcome
  int         m_pen;     // idle cycles still owed after a flush
  bit         m_valid;
  logic [3:0] m_op;
  bit         m_flush;
  bit         m_err;
  int         m_stall;
  bit         m_accepted;

  function automatic bit m_running();
    return !m_mem && !m_br && (m_pen == 0);
  endfunction

  function automatic bit m_ready();
    return (mq.size() < DEPTH) && (m_running() || m_mem);
  endfunction

  function automatic bit m_busy();
    return !m_running() || (mq.size() != 0);
  endfunction

  task automatic model_reset();
    mq.delete();
    m_mem = 0; m_age = 0; m_br = 0; m_pen = 0;
    m_valid = 0; m_op = 4'h0; m_flush = 0; m_err = 0; m_stall = 0;
  endtask

  // Advance one clock using the inputs present before the edge.
  task automatic model_step();
    bit acc;
    bit drop;
    logic [3:0] op;
    m_accepted = 0;
    if (rst) begin
      model_reset();
      return;
    end
    acc  = in_valid && m_ready();
    drop = 0;
    m_valid = 0;
    m_flush = 0;
    if (m_running()) begin
      if (mq.size() > 0) begin
        op = mq.pop_front();
        if (op != 4'h0) begin
          m_valid = 1;
          m_op    = op;
        end
        if (op == 4'h6 || op == 4'h7) begin
          m_mem = 1;
          m_age = 0;
        end else if (op == 4'h8) begin
          m_br = 1;
        end else if (op == 4'h9) begin
          m_flush = 1;
          drop    = 1;
          mq.delete();
          m_pen   = JPP;
        end
      end
    end else begin
      if (m_stall < 65535) m_stall++;
      if (m_mem) begin
        if (mem_done) m_mem = 0;
        else if (m_age == TMO - 1) begin
          m_err = 1;
          m_mem = 0;
        end else m_age++;
      end else if (m_br) begin
        if (br_resolved) begin
          m_br = 0;
          if (br_taken) begin
            m_flush = 1;
            mq.delete();
            m_pen = BRP;
          end
        end
      end else begin
        m_pen--;
      end
    end
    if (acc && !drop) mq.push_back(in_opcode);
    m_accepted = acc;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (started) begin
      chk("cu_valid",  {31'd0, cu_valid}, {31'd0, m_valid});
      chk("cu_opcode", {28'd0, cu_opcode}, {28'd0, m_op});
      chk("flush",     {31'd0, flush},    {31'd0, m_flush});
      chk("mem_err",   {31'd0, mem_err},  {31'd0, m_err});
      chk("stall_cnt", {16'd0, stall_cnt}, m_stall);
      chk("in_ready",  {31'd0, in_ready}, {31'd0, m_ready()});
      chk("busy",      {31'd0, busy},     {31'd0, m_busy()});
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    model_step();
  endtask

  task automatic drive(input bit v, input logic [3:0] op, input bit md = 0,
                       input bit brr = 0, input bit brt = 0);
    in_valid    = v;
    in_opcode   = op;
    mem_done    = md;
    br_resolved = brr;
    br_taken    = brt;
  endtask

  initial begin
    #500000;
    miscompares++;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit pend;
    logic [3:0] pend_op;
    rst = 1'b1;
    drive(0, 4'h0);
    model_reset();
    started = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    // ADD, SUB, AND back-to-back: three consecutive issues, 2 cycles latency.
    drive(1, 4'h1); tick();
    chk("t1_not_yet", {31'd0, cu_valid}, 32'd0);
    drive(1, 4'h2); tick();
    chk("t1_add", {27'd0, cu_valid, cu_opcode}, 32'h11);
    drive(1, 4'h3); tick();
    chk("t1_sub", {27'd0, cu_valid, cu_opcode}, 32'h12);
    drive(0, 4'h0); tick();
    chk("t1_and", {27'd0, cu_valid, cu_opcode}, 32'h13);
    tick();
    chk("t1_hold", {27'd0, cu_valid, cu_opcode}, 32'h03);
    chk("t1_stall", {16'd0, stall_cnt}, 32'd0);

    // NOP is dropped silently, XOR issues once.
    drive(1, 4'h0); tick();
    drive(1, 4'h5); tick();
    chk("t2_nop", {27'd0, cu_valid, cu_opcode}, 32'h03);
    drive(0, 4'h0); tick();
    chk("t2_xor", {27'd0, cu_valid, cu_opcode}, 32'h15);
    tick();
    chk("t2_hold", {27'd0, cu_valid, cu_opcode}, 32'h05);

    // LOAD then ADD, mem_done after 5 wait cycles.
    drive(1, 4'h6); tick();
    drive(1, 4'h1); tick();
    chk("t3_load", {27'd0, cu_valid, cu_opcode}, 32'h16);
    drive(0, 4'h0);
    repeat (4) tick();
    drive(0, 4'h0, 1); tick();
    chk("t3_stall", {16'd0, stall_cnt}, 32'd5);
    drive(0, 4'h0); tick();
    chk("t3_add", {27'd0, cu_valid, cu_opcode}, 32'h11);

    // LOAD with no mem_done: timeout after TMO wait cycles.
    drive(1, 4'h6); tick();
    drive(0, 4'h0); tick();
    repeat (7) tick();
    chk("t4_no_err_yet", {31'd0, mem_err}, 32'd0);
    chk("t4_busy", {31'd0, busy}, 32'd1);
    tick();
    chk("t4_err", {31'd0, mem_err}, 32'd1);
    chk("t4_run", {31'd0, busy}, 32'd0);
    chk("t4_stall", {16'd0, stall_cnt}, 32'd13);

    // Fill during MEM_WAIT, then taken branch flushes ADD/SUB/OR.
    drive(1, 4'h6); tick();
    drive(0, 4'h0); tick();
    drive(1, 4'h8); tick();
    drive(1, 4'h1); tick();
    drive(1, 4'h2); tick();
    chk("t5_ready3", {31'd0, in_ready}, 32'd1);
    drive(1, 4'h4); tick();
    chk("t5_full", {31'd0, in_ready}, 32'd0);
    drive(1, 4'h5); tick();
    chk("t5_held", {31'd0, in_ready}, 32'd0);
    drive(1, 4'h5, 1); tick();
    drive(1, 4'h5); tick();
    chk("t5_branch", {27'd0, cu_valid, cu_opcode}, 32'h18);
    chk("t5_brwait_ready", {31'd0, in_ready}, 32'd0);
    drive(1, 4'h5, 0, 1, 1); tick();
    chk("t5_flush", {31'd0, flush}, 32'd1);
    chk("t5_pen1_ready", {31'd0, in_ready}, 32'd0);
    drive(1, 4'h5); tick();
    chk("t5_flush_end", {31'd0, flush}, 32'd0);
    chk("t5_pen2_ready", {31'd0, in_ready}, 32'd0);
    tick();
    chk("t5_run_ready", {31'd0, in_ready}, 32'd1);
    tick();
    chk("t5_no_issue", {27'd0, cu_valid, cu_opcode}, 32'h08);
    drive(0, 4'h0); tick();
    chk("t5_xor", {27'd0, cu_valid, cu_opcode}, 32'h15);

    // JUMP with a same-cycle push: pushed opcode discarded.
    drive(1, 4'h9); tick();
    drive(1, 4'h1); tick();
    chk("t6_jump", {27'd0, cu_valid, cu_opcode}, 32'h19);
    chk("t6_flush", {31'd0, flush}, 32'd1);
    chk("t6_pen_ready", {31'd0, in_ready}, 32'd0);
    drive(0, 4'h0); tick();
    chk("t6_flush_end", {31'd0, flush}, 32'd0);
    chk("t6_empty", {31'd0, busy}, 32'd0);
    tick();
    chk("t6_no_issue", {31'd0, cu_valid}, 32'd0);

    // Reset during BR_WAIT with three buffered entries.
    drive(1, 4'h6); tick();
    drive(0, 4'h0); tick();
    drive(1, 4'h8); tick();
    drive(1, 4'h1); tick();
    drive(1, 4'h2); tick();
    drive(1, 4'h4); tick();
    drive(0, 4'h0, 1); tick();
    drive(0, 4'h0); tick();
    chk("t7_branch", {27'd0, cu_valid, cu_opcode}, 32'h18);
    @(posedge clk);
    #1;
    model_step();
    rst = 1'b1;
    model_reset();
    #1;
    chk("t7_rst_issue", {27'd0, cu_valid, cu_opcode}, 32'h00);
    chk("t7_rst_err", {31'd0, mem_err}, 32'd0);
    chk("t7_rst_stall", {16'd0, stall_cnt}, 32'd0);
    chk("t7_rst_busy", {31'd0, busy}, 32'd0);
    chk("t7_rst_ready", {31'd0, in_ready}, 32'd1);
    tick();
    rst = 1'b0;
    drive(1, 4'h2); tick();
    drive(0, 4'h0); tick();
    chk("t7_sub", {27'd0, cu_valid, cu_opcode}, 32'h12);
    tick();
    chk("t7_nothing_old", {31'd0, cu_valid}, 32'd0);

    // Randomized traffic; fetch holds an offered opcode until accepted.
    pend    = 0;
    pend_op = 4'h0;
    for (int i = 0; i < 3000; i++) begin
      if (!pend && $urandom_range(0, 2) != 0) begin
        pend    = 1;
        pend_op = 4'($urandom_range(0, 15));
      end
      in_valid    = pend;
      in_opcode   = pend ? pend_op : 4'($urandom_range(0, 15));
      mem_done    = ($urandom_range(0, 5) == 0);
      br_resolved = ($urandom_range(0, 2) == 0);
      br_taken    = 1'($urandom_range(0, 1));
      rst         = ($urandom_range(0, 999) == 0);
      if (rst) model_reset();
      tick();
      if (m_accepted) pend = 0;
    end
    rst = 1'b0;
    drive(0, 4'h0);
    repeat (20) tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
